// File: rtl/ac97_pcm_streamer.sv
// AC97 output-frame engine: buffers PCM frames, holds one codec register command,
// and serialises 256-bit frames (SYNC + SDATA_OUT) paced by a BIT_CLK tick.
module ac97_pcm_streamer #(
  parameter int unsigned NCH        = 2,
  parameter int unsigned SAMPLE_W   = 16,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          bit_tick,
  input  logic                          run,
  input  logic                          wr_valid,
  input  logic [NCH*SAMPLE_W-1:0]       wr_data,
  output logic                          wr_ready,
  input  logic                          cmd_valid,
  input  logic                          cmd_rw,
  input  logic [6:0]                    cmd_addr,
  input  logic [15:0]                   cmd_data,
  output logic                          cmd_ready,
  output logic                          sync,
  output logic                          sdata_out,
  output logic                          underrun,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int unsigned PCM_W     = NCH * SAMPLE_W;
  localparam int unsigned AW        = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned LW        = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned SLOT_W    = 20;
  localparam int unsigned TAG_W     = 16;
  localparam int unsigned FRAME_W   = 256;
  localparam int unsigned PCM_SLOTS = 10;
  localparam int unsigned PCM_REG_W = PCM_SLOTS * SLOT_W;
  localparam int unsigned SYNC_BITS = 16;

  logic [7:0]             bitcnt;
  logic [7:0]             bitcnt_next;
  logic                   fs;
  logic [FRAME_W-1:0]     shreg;
  logic [FRAME_W-1:0]     frame;

  logic                   cmd_rw_q;
  logic [6:0]             cmd_addr_q;
  logic [15:0]            cmd_data_q;
  logic                   cmd_held;
  logic                   cmd_take;

  logic [PCM_W-1:0]       mem [FIFO_DEPTH];
  logic [AW-1:0]          wr_ptr;
  logic [AW-1:0]          rd_ptr;
  logic [LW-1:0]          level_next;
  logic                   fifo_empty;
  logic                   push;
  logic                   pop;
  logic                   starve;
  logic [PCM_W-1:0]       pop_data;
  logic [NCH*SLOT_W-1:0]  pcm_bits;

  assign bitcnt_next = bitcnt + 8'd1;
  // First tick after reset is a frame start because bitcnt resets to 255.
  assign fs          = bit_tick && (bitcnt == 8'hFF);
  assign cmd_held    = !cmd_ready;
  assign cmd_take    = cmd_valid && cmd_ready;
  assign fifo_empty  = (fifo_level == LW'(0));
  assign push        = wr_valid && wr_ready;
  assign pop         = fs && run && !fifo_empty;
  assign starve      = fs && run && fifo_empty;
  assign pop_data    = mem[rd_ptr];

  // MSB-justify each popped sample inside its 20-bit slot.
  for (genvar g = 0; g < NCH; g++) begin : g_pcm
    assign pcm_bits[g*SLOT_W +: SLOT_W] =
      SLOT_W'(pop_data[g*SAMPLE_W +: SAMPLE_W]) << (SLOT_W - SAMPLE_W);
  end

  // Assemble the next frame: tag, command slots, then PCM slots 3..12.
  always_comb begin
    logic [TAG_W-1:0]     tag;
    logic [SLOT_W-1:0]    slot1;
    logic [SLOT_W-1:0]    slot2;
    logic [PCM_REG_W-1:0] pcm_region;
    tag        = '0;
    slot1      = '0;
    slot2      = '0;
    pcm_region = '0;
    if (cmd_held) begin
      slot1   = {cmd_rw_q, cmd_addr_q, 12'b0};
      tag[14] = 1'b1;
      if (!cmd_rw_q) begin
        slot2   = {cmd_data_q, 4'b0};
        tag[13] = 1'b1;
      end
    end
    if (pop) begin
      for (int g = 0; g < NCH; g++) begin
        pcm_region[PCM_REG_W-1-g*SLOT_W -: SLOT_W] = pcm_bits[g*SLOT_W +: SLOT_W];
        tag[12-g] = 1'b1;
      end
    end
    tag[15] = |tag[14:3];
    frame   = {tag, slot1, slot2, pcm_region};
  end

  // Next FIFO occupancy from this cycle's push/pop pair.
  always_comb begin
    level_next = fifo_level;
    case ({push, pop})
      2'b10:   level_next = fifo_level + LW'(1);
      2'b01:   level_next = fifo_level - LW'(1);
      default: level_next = fifo_level;
    endcase
  end

  // Bit counter, frame shift register and pin outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      bitcnt    <= 8'hFF;
      shreg     <= '0;
      sync      <= 1'b0;
      sdata_out <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      underrun <= starve;
      if (bit_tick) begin
        bitcnt <= bitcnt_next;
        sync   <= (bitcnt_next < 8'(SYNC_BITS));
        if (fs) begin
          sdata_out <= frame[FRAME_W-1];
          shreg     <= {frame[FRAME_W-2:0], 1'b0};
        end else begin
          sdata_out <= shreg[FRAME_W-1];
          shreg     <= {shreg[FRAME_W-2:0], 1'b0};
        end
      end
    end
  end

  // Single-entry command holder; released by the frame start that sends it.
  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_ready  <= 1'b1;
      cmd_rw_q   <= 1'b0;
      cmd_addr_q <= '0;
      cmd_data_q <= '0;
    end else if (cmd_take) begin
      cmd_ready  <= 1'b0;
      cmd_rw_q   <= cmd_rw;
      cmd_addr_q <= cmd_addr;
      cmd_data_q <= cmd_data;
    end else if (fs && cmd_held) begin
      cmd_ready  <= 1'b1;
    end
  end

  // FIFO pointers and occupancy; storage itself needs no reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      wr_ready   <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      fifo_level <= level_next;
      wr_ready   <= (level_next != LW'(FIFO_DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: tb/tb_ac97_pcm_streamer.sv
// Directed bench for ac97_pcm_streamer (NCH=2, SAMPLE_W=16, FIFO_DEPTH=8).
module tb_ac97_pcm_streamer;

  logic        clk = 1'b0;
  logic        rst;
  logic        bit_tick;
  logic        run;
  logic        wr_valid;
  logic [31:0] wr_data;
  logic        wr_ready;
  logic        cmd_valid;
  logic        cmd_rw;
  logic [6:0]  cmd_addr;
  logic [15:0] cmd_data;
  logic        cmd_ready;
  logic        sync;
  logic        sdata_out;
  logic        underrun;
  logic [3:0]  fifo_level;

  int passed = 0;
  int total  = 0;

  ac97_pcm_streamer #(.NCH(2), .SAMPLE_W(16), .FIFO_DEPTH(8)) dut (
    .clk(clk), .rst(rst), .bit_tick(bit_tick), .run(run),
    .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
    .cmd_valid(cmd_valid), .cmd_rw(cmd_rw), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .cmd_ready(cmd_ready), .sync(sync), .sdata_out(sdata_out),
    .underrun(underrun), .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [19:0] slot_of(input logic [255:0] f, input int n);
    return f[239-20*(n-1) -: 20];
  endfunction

  // One bit_tick pulse; returns at the negedge right after the ticked posedge.
  task automatic tick();
    bit_tick = 1'b1;
    @(negedge clk);
    bit_tick = 1'b0;
  endtask

  // 256 ticks starting at a frame start; captures the serial frame and side info.
  task automatic run_frame(input logic push_fs, input logic [31:0] d,
                           output logic [255:0] f, output int scnt, output int sbad,
                           output int ucnt, output logic cr0, output logic [3:0] lvl0,
                           output logic wr0);
    f = '0; scnt = 0; sbad = 0; ucnt = 0; cr0 = 1'b0; lvl0 = '0; wr0 = 1'b0;
    for (int k = 0; k < 256; k++) begin
      if (k == 0 && push_fs) begin
        wr_valid = 1'b1;
        wr_data  = d;
      end
      tick();
      wr_valid = 1'b0;
      f[255-k] = sdata_out;
      if (sync !== (k < 16)) sbad++;
      if (sync === 1'b1) scnt++;
      if (underrun === 1'b1) ucnt++;
      if (k == 0) begin
        cr0  = cmd_ready;
        lvl0 = fifo_level;
        wr0  = wr_ready;
      end
      @(negedge clk);
    end
  endtask

  task automatic push_one(input logic [31:0] d);
    wr_valid = 1'b1;
    wr_data  = d;
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  task automatic send_cmd(input logic rw, input logic [6:0] a, input logic [15:0] d);
    cmd_valid = 1'b1;
    cmd_rw    = rw;
    cmd_addr  = a;
    cmd_data  = d;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  initial begin
    logic [255:0] f;
    int           scnt, sbad, ucnt;
    logic         cr0, wr0;
    logic [3:0]   lvl0;

    rst = 1'b1; bit_tick = 1'b0; run = 1'b0; wr_valid = 1'b0; wr_data = '0;
    cmd_valid = 1'b0; cmd_rw = 1'b0; cmd_addr = '0; cmd_data = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_sync", 256'(sync), 256'd0);
    chk("rst_sdata", 256'(sdata_out), 256'd0);
    chk("rst_wr_ready", 256'(wr_ready), 256'd1);
    chk("rst_cmd_ready", 256'(cmd_ready), 256'd1);
    chk("rst_level", 256'(fifo_level), 256'd0);
    chk("rst_underrun", 256'(underrun), 256'd0);

    // Idle frame straight after reset
    run_frame(1'b0, 32'h0, f, scnt, sbad, ucnt, cr0, lvl0, wr0);
    chk("idle_frame", f, 256'd0);
    chk("idle_sync_cnt", 256'(scnt), 256'd16);
    chk("idle_sync_shape", 256'(sbad), 256'd0);
    chk("idle_underrun", 256'(ucnt), 256'd0);

    // Register write command
    send_cmd(1'b0, 7'h02, 16'h8080);
    chk("cmd_ready_drop", 256'(cmd_ready), 256'd0);
    run_frame(1'b0, 32'h0, f, scnt, sbad, ucnt, cr0, lvl0, wr0);
    chk("cmd_tag", 256'(f[255:240]), 256'h E000);
    chk("cmd_slot1", 256'(slot_of(f, 1)), 256'h02000);
    chk("cmd_slot2", 256'(slot_of(f, 2)), 256'h80800);
    chk("cmd_pcm_zero", 256'(f[199:0]), 256'd0);
    chk("cmd_ready_rise", 256'(cr0), 256'd1);

    // PCM stream, one frame
    run = 1'b1;
    push_one({16'h1234, 16'hABCD});
    chk("pcm_level1", 256'(fifo_level), 256'd1);
    run_frame(1'b0, 32'h0, f, scnt, sbad, ucnt, cr0, lvl0, wr0);
    chk("pcm_tag", 256'(f[255:240]), 256'h9800);
    chk("pcm_slot3", 256'(slot_of(f, 3)), 256'hABCD0);
    chk("pcm_slot4", 256'(slot_of(f, 4)), 256'h12340);
    chk("pcm_rest_zero", 256'(f[159:0]), 256'd0);
    chk("pcm_level0", 256'(lvl0), 256'd0);
    chk("pcm_no_underrun", 256'(ucnt), 256'd0);

    // Underrun: run with empty FIFO
    run_frame(1'b0, 32'h0, f, scnt, sbad, ucnt, cr0, lvl0, wr0);
    chk("ur_frame", f, 256'd0);
    chk("ur_pulse_cnt", 256'(ucnt), 256'd1);

    // Full FIFO, push refused on pop cycle, then drain across pointer wrap
    run = 1'b0;
    for (int i = 0; i < 8; i++) push_one({16'h0B00 + 16'(i), 16'h0A00 + 16'(i)});
    chk("full_level", 256'(fifo_level), 256'd8);
    chk("full_wr_ready", 256'(wr_ready), 256'd0);
    run = 1'b1;
    run_frame(1'b1, 32'hDEADBEEF, f, scnt, sbad, ucnt, cr0, lvl0, wr0);
    chk("full_pop_level", 256'(lvl0), 256'd7);
    chk("full_pop_wr_ready", 256'(wr0), 256'd1);
    chk("full_pop_slot3", 256'(slot_of(f, 3)), 256'h0A000);
    chk("full_pop_slot4", 256'(slot_of(f, 4)), 256'h0B000);
    push_one({16'h0B08, 16'h0A08});
    chk("refill_level", 256'(fifo_level), 256'd8);
    for (int j = 1; j <= 8; j++) begin
      run_frame(1'b0, 32'h0, f, scnt, sbad, ucnt, cr0, lvl0, wr0);
      chk("drain_slot3", 256'(slot_of(f, 3)), 256'({16'h0A00 + 16'(j), 4'h0}));
    end
    chk("drain_level", 256'(fifo_level), 256'd0);
    run = 1'b0;

    // Mid-frame reset with held command and queued PCM
    tick();
    @(negedge clk);
    push_one({16'h5555, 16'h6666});
    send_cmd(1'b1, 7'h26, 16'h0000);
    chk("mid_level", 256'(fifo_level), 256'd1);
    chk("mid_cmd_held", 256'(cmd_ready), 256'd0);
    for (int k = 0; k < 100; k++) begin
      tick();
      @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_sync", 256'(sync), 256'd0);
    chk("mid_rst_sdata", 256'(sdata_out), 256'd0);
    chk("mid_rst_level", 256'(fifo_level), 256'd0);
    chk("mid_rst_cmd_ready", 256'(cmd_ready), 256'd1);
    chk("mid_rst_wr_ready", 256'(wr_ready), 256'd1);
    rst = 1'b0;
    @(negedge clk);
    run = 1'b1;
    run_frame(1'b0, 32'h0, f, scnt, sbad, ucnt, cr0, lvl0, wr0);
    chk("post_rst_frame", f, 256'd0);
    chk("post_rst_sync_shape", 256'(sbad), 256'd0);
    chk("post_rst_underrun", 256'(ucnt), 256'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/ac97_pcm_streamer.md
# ac97_pcm_streamer

Parametrised AC97 output-frame engine that supersedes the fixed single-command audio path. It buffers multi-channel PCM frames in a FIFO, queues one codec register command at a time, and serialises complete 256-bit AC97 frames (SYNC plus SDATA_OUT) paced by a bit-clock tick. It sits between the CPU/audio DMA and the AC97 pins, downstream of the codec reset sequencer.

## Interface
- `NCH`, default 2: PCM channels, 1..4, mapped to slots 3..(2+NCH).
- `SAMPLE_W`, default 16: sample width, 16..20, MSB-justified in each 20-bit slot.
- `FIFO_DEPTH`, default 8: PCM frame FIFO entries; must be a power of 2, at least 2.
- `clk` — in, 1 — system clock. All logic is on posedge `clk`.
- `rst` — in, 1 — synchronous, active-high reset.
- `bit_tick` — in, 1 — one-`clk` pulse per AC97 BIT_CLK rising edge; already synchronised into the `clk` domain.
- `run` — in, 1 — enables PCM FIFO pops.
- `wr_valid` — in, 1 — PCM frame write request.
- `wr_data` — in, NCH*SAMPLE_W — channel 0 in the LSBs.
- `wr_ready` — out, 1 — equals !full.
- `cmd_valid` — in, 1 — register command request.
- `cmd_rw` — in, 1 — 1 = read, 0 = write.
- `cmd_addr` — in, 7 — codec register address.
- `cmd_data` — in, 16 — write data.
- `cmd_ready` — out, 1 — command slot free.
- `sync` — out, 1 — AC97 SYNC.
- `sdata_out` — out, 1 — AC97 SDATA_OUT.
- `underrun` — out, 1 — one-`clk` pulse.
- `fifo_level` — out, $clog2(FIFO_DEPTH)+1 — current FIFO occupancy.

## Operation
**Frame counter**
- 8-bit `bitcnt` advances on each `bit_tick` and wraps 255→0.
- Frame start (FS) is the `bit_tick` on which `bitcnt` is 255, or the first `bit_tick` after reset.

**Actions at FS**
- Build a 256-bit shift register for the next frame.
- If a command is held, load it into slots 1/2 and set `cmd_ready` back to 1.
- If `run`=1 and the FIFO is non-empty, pop one entry into slots 3..(2+NCH).
- If `run`=1 and the FIFO is empty, send no PCM slots and pulse `underrun`.

**Slot 0 tag (bits 15..0)**
- Bit 15 is frame-valid, the OR of all slot-valid bits.
- Bits 14 and 13 are the slot 1 and slot 2 valid bits. Slot 2 is valid only for writes.
- Bits 12..3 are the valid bits for slots 3..12. Only PCM slots that were loaded are set.
- Bits 2..0 are 0.

**Slot contents**
- Slot 1 = {cmd_rw, cmd_addr, 12'b0}.
- Slot 2 = {cmd_data, 4'b0}.
- PCM slots = {sample, (20-SAMPLE_W)'b0}.
- All unused slots are 0.

**Command handshake**
- A command is accepted when `cmd_valid` && `cmd_ready`. `cmd_ready` then drops the next cycle.
- The accepted command is held and transmitted in the next frame to start.
- `cmd_ready` rises the cycle after that FS.
- Commands are independent of `run`.

**FIFO**
- A push is accepted when `wr_valid` && `wr_ready`.
- A pop on FS and a push in the same cycle are both performed; level is unchanged.
- When the FIFO is full, `wr_ready`=0 even if a pop occurs in the same cycle.
- Pointers wrap modulo FIFO_DEPTH.

## Timing
- **Reset values:** `sync`=0, `sdata_out`=0, `bitcnt`=255, FIFO empty, `fifo_level`=0, `wr_ready`=1, `cmd_ready`=1, `underrun`=0, shift register = 0.
- **Output registration:** `sync` and `sdata_out` are registered. Both update in the `clk` cycle after `bit_tick`; there is no other latency.
- **SYNC:** 1 for frame bits 0..15, 0 for bits 16..255.
- **Bit order:** `sdata_out` sends frame bit 0 (tag bit 15) at `bitcnt`=0, MSB first per slot.
- **Underrun:** pulses in the cycle after FS.
- **Push/pop latency:** `fifo_level` updates one cycle after a push or pop.
- **Mid-frame reset:** `rst` asserted mid-frame abandons the frame immediately. Outputs take reset values the next cycle, and the held command and FIFO contents are discarded.
- **Idle:** with no `bit_tick`, all state holds.

## Test plan
- **Reset idle frame:** reset, then 256 `bit_tick`s with nothing queued → `sync` high for exactly 16 ticks and `sdata_out` all 0.
- **Write command:** write cmd addr 0x02, data 0x8080 → tag 0xE000. Slot 1 = 0x02000, slot 2 = 0x80800. `cmd_ready` rises after the next FS.
- **PCM stream:** NCH=2, SAMPLE_W=16, `run`=1, push {0x1234, 0xABCD} → tag 0x9800. Slot 3 = 0xABCD0, slot 4 = 0x12340. `fifo_level` goes 1→0.
- **Underrun:** `run`=1, FIFO empty at FS → `underrun` pulses once, tag 0x0000, all slots 0.
- **Full FIFO:** fill 8 entries → `wr_ready`=0 with `fifo_level`=8. A push on the FS pop cycle is refused and level goes to 7.
- **Mid-frame reset:** `rst` at `bitcnt`=100 → `sync`/`sdata_out` are 0 the next cycle. After release, the next frame starts on the first `bit_tick`.
